// File: rtl/sorter_pkg.sv
// -----------------------------------------------------------------------------
// sorter_pkg
//   Shared definitions for the median-filter sorting datapath.
//   - SORT_WIDTH      : default sample width (unsigned)
//   - sample_t        : one sample of SORT_WIDTH bits
//   - SORTER3_LATENCY : clocks from input sample to sorter3 output
//                       (1, or 2 when SORTER3_PIPE_EN is defined)
// Configuration macro: SORTER3_PIPE_EN
// -----------------------------------------------------------------------------
package sorter_pkg;

   localparam int unsigned SORT_WIDTH = 8;

   typedef logic [SORT_WIDTH-1:0] sample_t;

`ifdef SORTER3_PIPE_EN
   localparam int unsigned SORTER3_LATENCY = 2;
`else
   localparam int unsigned SORTER3_LATENCY = 1;
`endif

endpackage : sorter_pkg

// File: rtl/sorter_cas.sv
// -----------------------------------------------------------------------------
// sorter_cas
//   Combinational unsigned compare-exchange element.
//   Ports:
//     a, b  in   WIDTH  operands
//     lo    out  WIDTH  smaller operand (a on a tie)
//     hi    out  WIDTH  larger operand  (b on a tie)
// -----------------------------------------------------------------------------
module sorter_cas
   import sorter_pkg::*;
#(
   parameter int unsigned WIDTH = SORT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   always_comb begin
      lo = a;
      hi = b;
      // strict compare keeps a in lo on a tie
      if (a > b) begin
         lo = b;
         hi = a;
      end
   end

endmodule : sorter_cas

// File: rtl/sorter3.sv
// -----------------------------------------------------------------------------
// sorter3
//   Three-input unsigned sorter: min / median / max of one triple per clock,
//   presented on registered outputs.
//   Network: CAS(A,B) -> CAS(hi,C) -> CAS(lo,mid).
//   Ports:
//     iClk        in   1      clock, rising edge
//     iRst        in   1      synchronous active-high reset
//     iNumA/B/C   in   WIDTH  samples
//     oNumMin     out  WIDTH  smallest
//     oNumMedian  out  WIDTH  middle
//     oNumMax     out  WIDTH  largest
//   Configuration macro: SORTER3_PIPE_EN
//     defined   : register stage after CAS(A,B), latency 2
//     undefined : single output register, latency 1
// -----------------------------------------------------------------------------
module sorter3
   import sorter_pkg::*;
#(
   parameter int unsigned WIDTH = SORT_WIDTH
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [WIDTH-1:0] iNumA,
   input  logic [WIDTH-1:0] iNumB,
   input  logic [WIDTH-1:0] iNumC,
   output logic [WIDTH-1:0] oNumMin,
   output logic [WIDTH-1:0] oNumMedian,
   output logic [WIDTH-1:0] oNumMax
);

   logic [WIDTH-1:0] abLo;
   logic [WIDTH-1:0] abHi;
   logic [WIDTH-1:0] stLo;
   logic [WIDTH-1:0] stHi;
   logic [WIDTH-1:0] stC;
   logic [WIDTH-1:0] midLo;
   logic [WIDTH-1:0] maxHi;
   logic [WIDTH-1:0] minLo;
   logic [WIDTH-1:0] medHi;

   sorter_cas #(.WIDTH(WIDTH)) casAb (
      .a  (iNumA),
      .b  (iNumB),
      .lo (abLo),
      .hi (abHi)
   );

`ifdef SORTER3_PIPE_EN
   // C travels with the first-stage pair so the triple stays aligned
   always_ff @(posedge iClk) begin
      if (iRst) begin
         stLo <= '0;
         stHi <= '0;
         stC  <= '0;
      end else begin
         stLo <= abLo;
         stHi <= abHi;
         stC  <= iNumC;
      end
   end
`else
   always_comb begin
      stLo = abLo;
      stHi = abHi;
      stC  = iNumC;
   end
`endif

   sorter_cas #(.WIDTH(WIDTH)) casHiC (
      .a  (stHi),
      .b  (stC),
      .lo (midLo),
      .hi (maxHi)
   );

   sorter_cas #(.WIDTH(WIDTH)) casLoMid (
      .a  (stLo),
      .b  (midLo),
      .lo (minLo),
      .hi (medHi)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         oNumMin    <= '0;
         oNumMedian <= '0;
         oNumMax    <= '0;
      end else begin
         oNumMin    <= minLo;
         oNumMedian <= medHi;
         oNumMax    <= maxHi;
      end
   end

endmodule : sorter3

// File: tb/tb_sorter3.sv
// -----------------------------------------------------------------------------
// tb_sorter3
//   Self-checking bench for sorter3: reset, directed vector table,
//   back-to-back stream, mid-stream reset and random triples against a
//   reference sort. Honours SORTER3_PIPE_EN through SORTER3_LATENCY.
// -----------------------------------------------------------------------------
module tb_sorter3;
   import sorter_pkg::*;

   localparam int LAT = SORTER3_LATENCY;

   logic    iClk;
   logic    iRst;
   sample_t iNumA;
   sample_t iNumB;
   sample_t iNumC;
   sample_t oNumMin;
   sample_t oNumMedian;
   sample_t oNumMax;

   int checks = 0;
   int errors = 0;

   sorter3 #(.WIDTH(SORT_WIDTH)) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iNumA      (iNumA),
      .iNumB      (iNumB),
      .iNumC      (iNumC),
      .oNumMin    (oNumMin),
      .oNumMedian (oNumMedian),
      .oNumMax    (oNumMax)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef struct {
      string   name;
      sample_t a;
      sample_t b;
      sample_t c;
      sample_t eMin;
      sample_t eMed;
      sample_t eMax;
   } vec_t;

   typedef struct {
      sample_t a;
      sample_t b;
      sample_t c;
   } triple_t;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic drive(input sample_t a, input sample_t b, input sample_t c);
      iNumA = a;
      iNumB = b;
      iNumC = c;
   endtask

   task automatic check3(input string name, input sample_t eMin,
                         input sample_t eMed, input sample_t eMax);
      checks++;
      if (oNumMin !== eMin || oNumMedian !== eMed || oNumMax !== eMax) begin
         errors++;
         $display("FAIL %s: got %0d/%0d/%0d expected %0d/%0d/%0d", name,
                  oNumMin, oNumMedian, oNumMax, eMin, eMed, eMax);
      end
   endtask

   // reference model: plain exchange sort, independent of the CAS order
   function automatic triple_t refSort(input triple_t t);
      sample_t x;
      triple_t r;
      r = t;
      if (r.a > r.b) begin x = r.a; r.a = r.b; r.b = x; end
      if (r.b > r.c) begin x = r.b; r.b = r.c; r.c = x; end
      if (r.a > r.b) begin x = r.a; r.a = r.b; r.b = x; end
      return r;
   endfunction

   function automatic bit isPerm(input triple_t o, input triple_t t);
      return (o.a == t.a && o.b == t.b && o.c == t.c) ||
             (o.a == t.a && o.b == t.c && o.c == t.b) ||
             (o.a == t.b && o.b == t.a && o.c == t.c) ||
             (o.a == t.b && o.b == t.c && o.c == t.a) ||
             (o.a == t.c && o.b == t.a && o.c == t.b) ||
             (o.a == t.c && o.b == t.b && o.c == t.a);
   endfunction

   vec_t    vecs[8];
   triple_t perms[6];
   triple_t pend[$];

   initial begin
      vecs[0] = '{"v_311",       8'd3,   8'd1,   8'd1,   8'd1,   8'd1,   8'd3};
      vecs[1] = '{"v_12_7_4",    8'd12,  8'd7,   8'd4,   8'd4,   8'd7,   8'd12};
      vecs[2] = '{"v_3_10_4",    8'd3,   8'd10,  8'd4,   8'd3,   8'd4,   8'd10};
      vecs[3] = '{"v_equal",     8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2};
      vecs[4] = '{"v_extremes",  8'd255, 8'd0,   8'd128, 8'd0,   8'd128, 8'd255};
      vecs[5] = '{"v_sorted",    8'd1,   8'd2,   8'd3,   8'd1,   8'd2,   8'd3};
      vecs[6] = '{"v_tie_hi",    8'd9,   8'd9,   8'd1,   8'd1,   8'd9,   8'd9};
      vecs[7] = '{"v_rev",       8'd200, 8'd150, 8'd100, 8'd100, 8'd150, 8'd200};

      perms[0] = '{8'd5,   8'd9,   8'd200};
      perms[1] = '{8'd5,   8'd200, 8'd9};
      perms[2] = '{8'd9,   8'd5,   8'd200};
      perms[3] = '{8'd9,   8'd200, 8'd5};
      perms[4] = '{8'd200, 8'd5,   8'd9};
      perms[5] = '{8'd200, 8'd9,   8'd5};

      // reset with non-zero inputs, then release
      iRst = 1'b1;
      drive(8'd7, 8'd3, 8'd9);
      repeat (3) tick();
      check3("reset", 8'd0, 8'd0, 8'd0);
      iRst = 1'b0;
      drive(8'd0, 8'd0, 8'd4);
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) check3("release_fill", 8'd0, 8'd0, 8'd0);
      end
      check3("release_004", 8'd0, 8'd0, 8'd4);

      // directed table
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].c);
         repeat (LAT) tick();
         check3(vecs[i].name, vecs[i].eMin, vecs[i].eMed, vecs[i].eMax);
      end

      // back-to-back permutations, no bubbles
      drive(8'd1, 8'd1, 8'd1);
      repeat (LAT) tick();
      for (int i = 0; i < 6; i++) begin
         drive(perms[i].a, perms[i].b, perms[i].c);
         tick();
         if (i >= LAT - 1) check3("stream_perm", 8'd5, 8'd9, 8'd200);
      end
      drive(8'd0, 8'd0, 8'd0);
      for (int t = 0; t < LAT - 1; t++) begin
         tick();
         check3("stream_tail", 8'd5, 8'd9, 8'd200);
      end
      tick();
      check3("stream_after", 8'd0, 8'd0, 8'd0);

      // reset in the middle of an active stream
      drive(8'd10, 8'd20, 8'd30);
      tick();
      drive(8'd40, 8'd50, 8'd60);
      tick();
      iRst = 1'b1;
      drive(8'd70, 8'd80, 8'd90);
      tick();
      check3("rst_mid", 8'd0, 8'd0, 8'd0);
      iRst = 1'b0;
      drive(8'd3, 8'd1, 8'd2);
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) check3("rst_no_stale", 8'd0, 8'd0, 8'd0);
      end
      check3("rst_first_new", 8'd1, 8'd2, 8'd3);

      // random triples against the reference sort
      pend.delete();
      for (int n = 0; n < 10000; n++) begin
         triple_t t;
         triple_t e;
         triple_t o;
         t.a = sample_t'($urandom_range(0, 255));
         t.b = sample_t'($urandom_range(0, 255));
         t.c = sample_t'($urandom_range(0, 255));
         drive(t.a, t.b, t.c);
         pend.push_back(t);
         tick();
         if (pend.size() == LAT) begin
            t = pend.pop_front();
            e = refSort(t);
            check3("rand_sort", e.a, e.b, e.c);
            o = '{oNumMin, oNumMedian, oNumMax};
            checks++;
            if (!(oNumMin <= oNumMedian && oNumMedian <= oNumMax)) begin
               errors++;
               $display("FAIL rand_order: got %0d/%0d/%0d expected nondecreasing",
                        oNumMin, oNumMedian, oNumMax);
            end
            checks++;
            if (!isPerm(o, t)) begin
               errors++;
               $display("FAIL rand_perm: got %0d/%0d/%0d expected permutation of %0d,%0d,%0d",
                        oNumMin, oNumMedian, oNumMax, t.a, t.b, t.c);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sorter3
